// File: rtl/mmcm_drp_reconfig.sv
`default_nettype none
// ============================================================================
//  Module   : mmcm_drp_reconfig
//  Purpose  : Reprograms the deserializer MMCM through its DRP port whenever
//             the DCO frequency counter reports a new frequency range. The
//             sequence holds the MMCM in reset, read-modify-writes every
//             table register for the selected mode, releases reset and waits
//             for lock. All timing is in the DRP reference clock domain.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    drp_refclk_i     100 MHz DRP reference clock (only clock)
//    reset_i          synchronous active-high reset
//    freq_mode_i      range code from the frequency counter (valid 0..4)
//    count_done_i     counter-done level, rising edge starts a sequence
//    mmcm_locked_i    MMCM LOCKED (asynchronous, synchronised here)
//    drp_do_i         DRP read data
//    drp_drdy_i       DRP ready
//    drp_den_o        DRP enable (one-cycle pulse)
//    drp_dwe_o        DRP write enable (only together with drp_den_o)
//    drp_daddr_o      DRP address
//    drp_di_o         DRP write data
//    mmcm_rst_o       MMCM reset
//    reconfig_busy_o  sequence in progress
//    reconfig_done_o  last sequence completed
//    reconfig_error_o last sequence failed
//    err_code_o       00 none, 01 invalid mode, 10 drdy timeout, 11 lock timeout
//    applied_mode_o   last successfully applied mode, 3'b111 = none
// ============================================================================
module mmcm_drp_reconfig #(
    parameter int                          NUM_REGS     = 5,
    parameter logic [5*NUM_REGS*39-1:0]    CFG_TABLE    = '0,
    parameter int                          DRDY_TIMEOUT = 1024,
    parameter int                          LOCK_TIMEOUT = 65535
) (
    input  logic        drp_refclk_i,
    input  logic        reset_i,
    input  logic [2:0]  freq_mode_i,
    input  logic        count_done_i,
    input  logic        mmcm_locked_i,
    input  logic [15:0] drp_do_i,
    input  logic        drp_drdy_i,
    output logic        drp_den_o,
    output logic        drp_dwe_o,
    output logic [6:0]  drp_daddr_o,
    output logic [15:0] drp_di_o,
    output logic        mmcm_rst_o,
    output logic        reconfig_busy_o,
    output logic        reconfig_done_o,
    output logic        reconfig_error_o,
    output logic [1:0]  err_code_o,
    output logic [2:0]  applied_mode_o
);

    localparam int ENTRY_W = 39;
    localparam int RW      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int TMAX    = (DRDY_TIMEOUT > LOCK_TIMEOUT) ? DRDY_TIMEOUT : LOCK_TIMEOUT;
    localparam int TW      = (TMAX > 1) ? $clog2(TMAX) : 1;

    localparam logic [2:0] MODE_NONE = 3'b111;
    localparam logic [2:0] MODE_MAX  = 3'd4;

    localparam logic [1:0] ERR_NONE  = 2'b00;
    localparam logic [1:0] ERR_MODE  = 2'b01;
    localparam logic [1:0] ERR_DRDY  = 2'b10;
    localparam logic [1:0] ERR_LOCK  = 2'b11;

    typedef enum logic [3:0] {
        S_IDLE       = 4'd0,
        S_ASSERT_RST = 4'd1,
        S_READ       = 4'd2,
        S_WAIT_RD    = 4'd3,
        S_WRITE      = 4'd4,
        S_WAIT_WR    = 4'd5,
        S_RELEASE    = 4'd6,
        S_WAIT_LOCK  = 4'd7,
        S_DONE       = 4'd8,
        S_ERROR      = 4'd9
    } state_t;

    state_t           state_q, state_d;
    logic             count_done_q;
    logic [2:0]       mode_q, mode_d;
    logic [RW-1:0]    r_q, r_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic [15:0]      rd_q, rd_d;
    logic             mmcm_rst_q, mmcm_rst_d;
    logic [1:0]       err_q, err_d;
    logic [2:0]       applied_q, applied_d;
    logic             lock_meta_q, lock_sync_q;

    logic             trig;
    logic [2:0]       mode_idx;
    logic [ENTRY_W-1:0] entry;
    logic [6:0]       cfg_addr;
    logic [15:0]      cfg_mask;
    logic [15:0]      cfg_data;
    logic [15:0]      wdata;

    assign trig = count_done_i & ~count_done_q;

    // An out-of-range mode never reaches the DRP states, but clamping keeps
    // the table lookup inside the parameter for every possible mode_q value.
    assign mode_idx = (mode_q > MODE_MAX) ? 3'd0 : mode_q;
    assign entry    = CFG_TABLE[(int'(mode_idx) * NUM_REGS + int'(r_q)) * ENTRY_W +: ENTRY_W];
    assign cfg_addr = entry[38:32];
    assign cfg_mask = entry[31:16];
    assign cfg_data = entry[15:0];

    // Mask bit 1 keeps the bit read back from the MMCM.
    assign wdata = (rd_q & cfg_mask) | (cfg_data & ~cfg_mask);

    always_ff @(posedge drp_refclk_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge drp_refclk_i) begin
        if (reset_i) begin
            count_done_q <= 1'b0;
            mode_q       <= 3'd0;
            r_q          <= '0;
            timer_q      <= '0;
            rd_q         <= 16'd0;
            mmcm_rst_q   <= 1'b0;
            err_q        <= ERR_NONE;
            applied_q    <= MODE_NONE;
            lock_meta_q  <= 1'b0;
            lock_sync_q  <= 1'b0;
        end else begin
            count_done_q <= count_done_i;
            mode_q       <= mode_d;
            r_q          <= r_d;
            timer_q      <= timer_d;
            rd_q         <= rd_d;
            mmcm_rst_q   <= mmcm_rst_d;
            err_q        <= err_d;
            applied_q    <= applied_d;
            lock_meta_q  <= mmcm_locked_i;
            lock_sync_q  <= lock_meta_q;
        end
    end

    always_comb begin
        state_d          = state_q;
        mode_d           = mode_q;
        r_d              = r_q;
        timer_d          = timer_q;
        rd_d             = rd_q;
        mmcm_rst_d       = mmcm_rst_q;
        err_d            = err_q;
        applied_d        = applied_q;
        drp_den_o        = 1'b0;
        drp_dwe_o        = 1'b0;
        drp_daddr_o      = 7'd0;
        drp_di_o         = 16'd0;
        reconfig_busy_o  = 1'b1;
        reconfig_done_o  = 1'b0;
        reconfig_error_o = 1'b0;

        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                reconfig_busy_o  = 1'b0;
                reconfig_done_o  = (state_q == S_DONE);
                reconfig_error_o = (state_q == S_ERROR);
                if (trig) begin
                    mode_d = freq_mode_i;
                    err_d  = ERR_NONE;
                    if (freq_mode_i > MODE_MAX) begin
                        state_d    = S_ERROR;
                        err_d      = ERR_MODE;
                        mmcm_rst_d = 1'b0;
                    end else if (freq_mode_i == applied_q) begin
                        // Already running this configuration: nothing to touch.
                        state_d    = S_DONE;
                        mmcm_rst_d = 1'b0;
                    end else begin
                        state_d = S_ASSERT_RST;
                        r_d     = '0;
                    end
                end
            end

            S_ASSERT_RST: begin
                mmcm_rst_d = 1'b1;
                state_d    = S_READ;
            end

            S_READ: begin
                drp_den_o   = 1'b1;
                drp_daddr_o = cfg_addr;
                timer_d     = '0;
                state_d     = S_WAIT_RD;
            end

            S_WAIT_RD: begin
                drp_daddr_o = cfg_addr;
                if (drp_drdy_i) begin
                    rd_d    = drp_do_i;
                    state_d = S_WRITE;
                end else if (timer_q == TW'(DRDY_TIMEOUT - 1)) begin
                    state_d   = S_ERROR;
                    err_d     = ERR_DRDY;
                    applied_d = MODE_NONE;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end

            S_WRITE: begin
                drp_den_o   = 1'b1;
                drp_dwe_o   = 1'b1;
                drp_daddr_o = cfg_addr;
                drp_di_o    = wdata;
                timer_d     = '0;
                state_d     = S_WAIT_WR;
            end

            S_WAIT_WR: begin
                drp_daddr_o = cfg_addr;
                drp_di_o    = wdata;
                if (drp_drdy_i) begin
                    if (int'(r_q) < NUM_REGS - 1) begin
                        r_d     = r_q + RW'(1);
                        state_d = S_READ;
                    end else begin
                        state_d = S_RELEASE;
                    end
                end else if (timer_q == TW'(DRDY_TIMEOUT - 1)) begin
                    state_d   = S_ERROR;
                    err_d     = ERR_DRDY;
                    applied_d = MODE_NONE;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end

            S_RELEASE: begin
                mmcm_rst_d = 1'b0;
                timer_d    = '0;
                state_d    = S_WAIT_LOCK;
            end

            S_WAIT_LOCK: begin
                if (lock_sync_q) begin
                    state_d   = S_DONE;
                    applied_d = mode_q;
                end else if (timer_q == TW'(LOCK_TIMEOUT - 1)) begin
                    state_d   = S_ERROR;
                    err_d     = ERR_LOCK;
                    applied_d = MODE_NONE;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign mmcm_rst_o     = mmcm_rst_q;
    assign err_code_o     = err_q;
    assign applied_mode_o = applied_q;

endmodule
`default_nettype wire
